// File: rtl/pc_if.sv
// Request/response bundle between the control/branch logic and the program counter.
interface pc_if #(
    parameter int XLEN = 32
);
    logic            i_stall;
    logic            i_br_taken;
    logic [XLEN-1:0] i_br_target;
    logic            i_jmp;
    logic [XLEN-1:0] i_jmp_target;
    logic            i_call;
    logic            i_ret;
    logic            i_trap;
    logic [XLEN-1:0] o_pc;
    logic [XLEN-1:0] o_pc_plus;
    logic [1:0]      o_exc;
    logic            o_ras_empty;
    logic            o_ras_full;

    modport master (
        output i_stall, i_br_taken, i_br_target, i_jmp, i_jmp_target,
               i_call, i_ret, i_trap,
        input  o_pc, o_pc_plus, o_exc, o_ras_empty, o_ras_full
    );

    modport slave (
        input  i_stall, i_br_taken, i_br_target, i_jmp, i_jmp_target,
               i_call, i_ret, i_trap,
        output o_pc, o_pc_plus, o_exc, o_ras_empty, o_ras_full
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter with next-PC selection, a circular return-address stack,
// and a registered cause code for trap / misaligned / underflow redirects.
module pc_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 'h0,
    parameter logic [XLEN-1:0] TRAP_VEC  = 'h80,
    parameter int              INC       = 4,
    parameter int              RAS_DEPTH = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    pc_if.slave  bus
);
    localparam int              PW      = $clog2(RAS_DEPTH);
    localparam logic [XLEN-1:0] INC_V   = XLEN'(INC);
    localparam logic [PW:0]     DEPTH_V = (PW + 1)'(RAS_DEPTH);

    typedef enum logic [1:0] {
        EXC_NONE      = 2'd0,
        EXC_TRAP      = 2'd1,
        EXC_MISALIGN  = 2'd2,
        EXC_UNDERFLOW = 2'd3
    } exc_e;

    logic [XLEN-1:0] pc_q, pc_d;
    exc_e            exc_q, exc_d;
    logic [PW-1:0]   top_q, top_d;
    logic [PW:0]     cnt_q, cnt_d;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [XLEN-1:0] ras_d [RAS_DEPTH];

    logic [XLEN-1:0] pc_plus;
    logic [XLEN-1:0] target;
    logic            redirect;
    logic            push;
    logic            pop;

    // Sequential address wraps modulo 2^XLEN without any flag.
    assign pc_plus = pc_q + INC_V;

    // Select the redirect source and the RAS side effect in priority order.
    always_comb begin
        target   = '0;
        redirect = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        pc_d     = pc_plus;
        exc_d    = EXC_NONE;
        if (bus.i_trap) begin
            pc_d  = TRAP_VEC;
            exc_d = EXC_TRAP;
        end else if (bus.i_stall) begin
            pc_d  = pc_q;
            exc_d = EXC_NONE;
        end else if (bus.i_ret) begin
            if (cnt_q == '0) begin
                pc_d  = TRAP_VEC;
                exc_d = EXC_UNDERFLOW;
            end else begin
                target   = ras_q[top_q];
                redirect = 1'b1;
                pop      = 1'b1;
            end
        end else if (bus.i_jmp) begin
            target   = bus.i_jmp_target;
            redirect = 1'b1;
            push     = bus.i_call;
        end else if (bus.i_br_taken) begin
            target   = bus.i_br_target;
            redirect = 1'b1;
        end

        // Misaligned redirects still perform their push/pop.
        if (redirect) begin
            if (target[1:0] != 2'b00) begin
                pc_d  = TRAP_VEC;
                exc_d = EXC_MISALIGN;
            end else begin
                pc_d  = target;
                exc_d = EXC_NONE;
            end
        end
    end

    // Circular RAS update; a push when full overwrites the oldest entry.
    always_comb begin
        ras_d = ras_q;
        top_d = top_q;
        cnt_d = cnt_q;
        if (push) begin
            top_d        = top_q + 1'b1;
            ras_d[top_d] = pc_plus;
            if (cnt_q != DEPTH_V) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop) begin
            top_d = top_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    // State registers; reset forces the PC, cause and stack bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q  <= RESET_VEC;
            exc_q <= EXC_NONE;
            top_q <= '0;
            cnt_q <= '0;
            ras_q <= '{default: '0};
        end else begin
            pc_q  <= pc_d;
            exc_q <= exc_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
            ras_q <= ras_d;
        end
    end

    assign bus.o_pc        = pc_q;
    assign bus.o_pc_plus   = pc_plus;
    assign bus.o_exc       = exc_q;
    assign bus.o_ras_empty = (cnt_q == '0);
    assign bus.o_ras_full  = (cnt_q == DEPTH_V);
endmodule

// File: tb/tb_pc_unit.sv
// Directed and randomized checks of pc_unit against a queue-based model.
module tb_pc_unit;
    localparam logic [31:0] TRAP = 32'h80;
    localparam int          DEPTH = 4;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    pc_if #(.XLEN(32)) bus ();

    pc_unit dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: PC, cause and a return stack held as a bounded queue.
    logic [31:0] m_pc;
    logic [1:0]  m_exc;
    logic [31:0] m_ras [$];

    task automatic model_reset();
        m_pc  = 32'h0;
        m_exc = 2'd0;
        m_ras.delete();
    endtask

    task automatic model_go(input logic [31:0] t);
        if (t % 4 != 0) begin
            m_pc  = TRAP;
            m_exc = 2'd2;
        end else begin
            m_pc  = t;
            m_exc = 2'd0;
        end
    endtask

    task automatic model_step(input logic st, input logic br, input logic [31:0] brt,
                              input logic jm, input logic [31:0] jt,
                              input logic cl, input logic rt, input logic tr);
        logic [31:0] t;
        if (tr) begin
            m_pc  = TRAP;
            m_exc = 2'd1;
        end else if (st) begin
            m_exc = 2'd0;
        end else if (rt) begin
            if (m_ras.size() == 0) begin
                m_pc  = TRAP;
                m_exc = 2'd3;
            end else begin
                t = m_ras.pop_back();
                model_go(t);
            end
        end else if (jm) begin
            if (cl) begin
                m_ras.push_back(m_pc + 32'd4);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
            model_go(jt);
        end else if (br) begin
            model_go(brt);
        end else begin
            m_pc  = m_pc + 32'd4;
            m_exc = 2'd0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_pc"},    bus.o_pc, m_pc);
        chk({tag, "_exc"},   32'(bus.o_exc), 32'(m_exc));
        chk({tag, "_plus"},  bus.o_pc_plus, m_pc + 32'd4);
        chk({tag, "_empty"}, 32'(bus.o_ras_empty), 32'(m_ras.size() == 0));
        chk({tag, "_full"},  32'(bus.o_ras_full), 32'(m_ras.size() == DEPTH));
    endtask

    task automatic clear_inputs();
        bus.i_stall      = 1'b0;
        bus.i_br_taken   = 1'b0;
        bus.i_br_target  = '0;
        bus.i_jmp        = 1'b0;
        bus.i_jmp_target = '0;
        bus.i_call       = 1'b0;
        bus.i_ret        = 1'b0;
        bus.i_trap       = 1'b0;
    endtask

    task automatic step(input string tag, input logic st, input logic br, input logic [31:0] brt,
                        input logic jm, input logic [31:0] jt,
                        input logic cl, input logic rt, input logic tr);
        bus.i_stall      = st;
        bus.i_br_taken   = br;
        bus.i_br_target  = brt;
        bus.i_jmp        = jm;
        bus.i_jmp_target = jt;
        bus.i_call       = cl;
        bus.i_ret        = rt;
        bus.i_trap       = tr;
        @(posedge clk);
        #1;
        model_step(st, br, brt, jm, jt, cl, rt, tr);
        check_model(tag);
        clear_inputs();
    endtask

    // Shorthands for the common directed requests.
    task automatic seq(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic jump(input string tag, input logic [31:0] t, input logic cl);
        step(tag, 0, 0, 0, 1, t, cl, 0, 0);
    endtask
    task automatic ret(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        clear_inputs();
        model_reset();

        // Reset and sequential run.
        repeat (2) @(posedge clk);
        #1;
        check_model("rst");
        chk("rst_pc_const", bus.o_pc, 32'h0);
        rst_n = 1'b1;
        seq("seq1"); chk("seq1_const", bus.o_pc, 32'h4);
        seq("seq2"); chk("seq2_const", bus.o_pc, 32'h8);
        seq("seq3"); chk("seq3_const", bus.o_pc, 32'hC);

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_pc", bus.o_pc, 32'h0);
        chk("async_rst_exc", 32'(bus.o_exc), 32'h0);
        @(posedge clk);
        #1;
        check_model("rst_hold");
        rst_n = 1'b1;
        repeat (4) seq("seq_after_rst");
        chk("pc_at_10", bus.o_pc, 32'h10);

        // Stall and priority.
        step("stall1", 1, 0, 0, 0, 0, 0, 0, 0);
        step("stall2", 1, 0, 0, 0, 0, 0, 0, 0);
        chk("stall_hold", bus.o_pc, 32'h10);
        step("stall_br", 1, 1, 32'h40, 0, 0, 0, 0, 0);
        chk("stall_br_hold", bus.o_pc, 32'h10);
        step("stall_trap", 1, 0, 0, 0, 0, 0, 0, 1);
        chk("stall_trap_pc", bus.o_pc, TRAP);
        chk("stall_trap_exc", 32'(bus.o_exc), 32'd1);

        // Call and return.
        jump("to20", 32'h20, 0);
        jump("call100", 32'h100, 1);
        chk("call_pc", bus.o_pc, 32'h100);
        chk("call_nonempty", 32'(bus.o_ras_empty), 32'd0);
        ret("ret24");
        chk("ret_pc", bus.o_pc, 32'h24);
        chk("ret_empty", 32'(bus.o_ras_empty), 32'd1);

        // Five nested calls overflow a four-deep stack.
        jump("to0", 32'h0, 0);
        for (int i = 1; i <= 5; i++) jump("nest", 32'(i * 16), 1);
        chk("ras_full", 32'(bus.o_ras_full), 32'd1);
        ret("r1"); chk("r1_pc", bus.o_pc, 32'h44);
        ret("r2"); chk("r2_pc", bus.o_pc, 32'h34);
        ret("r3"); chk("r3_pc", bus.o_pc, 32'h24);
        ret("r4"); chk("r4_pc", bus.o_pc, 32'h14);
        ret("r5");
        chk("underflow_pc", bus.o_pc, TRAP);
        chk("underflow_exc", 32'(bus.o_exc), 32'd3);

        // Misaligned redirects.
        step("mis_br", 0, 1, 32'h102, 0, 0, 0, 0, 0);
        chk("mis_br_pc", bus.o_pc, TRAP);
        chk("mis_br_exc", 32'(bus.o_exc), 32'd2);
        jump("to50", 32'h50, 0);
        jump("mis_call", 32'h203, 1);
        chk("mis_call_exc", 32'(bus.o_exc), 32'd2);
        ret("mis_call_ret");
        chk("mis_call_top", bus.o_pc, 32'h54);

        // Simultaneous requests and address wrap.
        jump("call300", 32'h300, 1);
        step("ret_wins", 0, 1, 32'h500, 1, 32'h400, 1, 1, 0);
        chk("ret_wins_pc", bus.o_pc, 32'h58);
        chk("ret_wins_nopush", 32'(bus.o_ras_empty), 32'd1);
        step("jmp_over_br", 0, 1, 32'h700, 1, 32'h600, 0, 0, 0);
        chk("jmp_over_br_pc", bus.o_pc, 32'h600);
        step("call_no_jmp", 0, 0, 0, 0, 0, 1, 0, 0);
        jump("to_top", 32'hFFFF_FFFC, 0);
        chk("top_plus", bus.o_pc_plus, 32'h0);
        seq("wrap");
        chk("wrap_pc", bus.o_pc, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] brt;
            logic [31:0] jt;
            brt = $urandom & 32'hFFFF_FFFC;
            jt  = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) brt[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) jt[1:0]  = 2'($urandom_range(1, 3));
            step("rand",
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0), brt,
                 ($urandom_range(0, 2) == 0), jt,
                 ($urandom_range(0, 1) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 19) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised next-generation program counter for the single-cycle core.
- Holds the current PC and selects the next PC from the following sources: sequential increment, branch, jump, return (from an internal return-address stack), or trap vector.
- Supports stall. Detects misaligned redirect targets and return-stack underflow, and reports a cause code.
- Sits between the control/branch logic and the instruction memory address.

Parameters:
- XLEN, 32, PC/address width in bits.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset (XLEN bits).
- TRAP_VEC, 32'h0000_0080, PC loaded on any trap or exception.
- INC, 4, sequential increment (bytes per instruction).
- RAS_DEPTH, 4, return-address stack entries (power of 2, ≥2).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_stall  in  1  hold PC and RAS this cycle.
- i_br_taken  in  1  conditional branch taken.
- i_br_target  in  XLEN  branch target.
- i_jmp  in  1  unconditional jump.
- i_jmp_target  in  XLEN  jump target.
- i_call  in  1  with i_jmp: push o_pc+INC onto RAS.
- i_ret  in  1  redirect to RAS top and pop.
- i_trap  in  1  external trap request.
- o_pc  out  XLEN  current PC (registered).
- o_pc_plus  out  XLEN  o_pc+INC (combinational).
- o_exc  out  2  registered cause of the last PC update: 0 none, 1 external trap, 2 misaligned target, 3 RAS underflow.
- o_ras_empty  out  1  RAS count == 0.
- o_ras_full  out  1  RAS count == RAS_DEPTH.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low: i_rst_n=0 immediately forces o_pc=RESET_VEC, o_exc=0, RAS count=0 and top pointer=0; RAS entry contents are don't-care.
- Reset mid-operation: asserting i_rst_n between edges overrides everything. The first edge after release performs a normal update from RESET_VEC.
- Update timing: on each rising edge, o_pc <= next_pc. Redirect latency is 1 cycle: a request presented in cycle N appears on o_pc in cycle N+1.
- Next-PC priority, highest first:
  1. i_trap -> TRAP_VEC, o_exc=1. Trap overrides i_stall.
  2. i_stall -> o_pc held, o_exc=0, RAS unchanged. All requests other than trap are ignored.
  3. i_ret -> if RAS empty: TRAP_VEC, o_exc=3, no pop. Otherwise: RAS top, pop.
  4. i_jmp -> i_jmp_target. If i_call is also set: push o_pc+INC.
  5. i_br_taken -> i_br_target.
  6. Otherwise -> o_pc+INC, o_exc=0.
- Misalignment: for sources 3–5, if target[1:0] != 0, next PC is TRAP_VEC and o_exc=2.
  - The RAS side effect still occurs: a misaligned call still pushes, and a misaligned return still pops.
  - Sequential and trap paths are never checked.
- i_call without i_jmp is ignored.
- i_ret together with i_jmp: return wins. The jump and any call are ignored, so no push occurs.
- RAS operation:
  - Circular buffer with a top pointer and a saturating count 0..RAS_DEPTH.
  - Push writes at top+1 and advances the pointer.
  - Push when full overwrites the oldest entry. Count stays at RAS_DEPTH; the pointer still wraps modulo RAS_DEPTH.
  - Pop decrements the pointer (wrapping) and the count.
  - Push and pop never occur in the same cycle.
- Arithmetic: o_pc+INC is modulo 2^XLEN. All-ones minus 3 plus 4 wraps to 0 with no flag.
- o_exc is registered with o_pc and is valid for exactly the cycle its PC is presented. It is held during a stall only if it was set in the previous cycle; in practice a stall writes 0, per the rule above.
- No combinational path exists from any input to o_pc. o_pc_plus depends only on o_pc.

Test Plan:
- Reset/sequential: hold i_rst_n=0, then release. o_pc=0x0, then 0x4, 0x8, 0xC on successive edges. Assert i_rst_n=0 mid-cycle: o_pc drops to 0x0 before the next edge.
- Stall and priority: at o_pc=0x10, i_stall=1 for 2 cycles -> o_pc stays 0x10. Stall with i_br_taken=1 and target 0x40 -> stays 0x10. Stall with i_trap=1 -> o_pc=0x80, o_exc=1.
- Call/return: at 0x20, i_jmp=1, i_call=1, target 0x100 -> o_pc=0x100, o_ras_empty=0. Then i_ret=1 -> o_pc=0x24, o_ras_empty=1.
- RAS overflow (depth 4): five nested calls from 0x0, 0x10, 0x20, 0x30, 0x40 -> o_ras_full=1. Four returns yield 0x44, 0x34, 0x24, 0x14. A fifth return -> o_pc=0x80, o_exc=3.
- Misalignment: i_br_taken=1 with target 0x102 -> o_pc=0x80, o_exc=2. A call to 0x203 at o_pc=0x50 -> o_pc=0x80, o_exc=2, and the RAS top becomes 0x54.
- Simultaneous requests and wrap:
  - i_ret + i_jmp + i_br_taken together -> the return wins.
  - i_jmp + i_br_taken -> the jump target.
  - With o_pc=0xFFFF_FFFC and no request -> o_pc=0x0.
